// File: rtl/instr_issuer.sv
// instr_issuer: sequences commands into held 10-bit words {op,field,addr}
// for a reg2mem block and returns LOAD results over a valid/ready channel.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/
//   cmd_field/cmd_addr (command in); instruction (word out); res (load
//   result in); rsp_valid/rsp_ready/rsp_data (response out); busy.
// Option: define ISSUER_SKID_EN to add a one-entry command buffer so a
//   command can be accepted while a previous one is still in flight.
module instr_issuer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_field,
  input  logic [3:0] cmd_addr,
  output logic [9:0] instruction,
  input  logic [3:0] res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  // LOAD of address 0: harmless word presented whenever nothing is issued
  localparam logic [9:0] IDLE_WORD = 10'b1100000000;
  localparam logic [1:0] OP_LOAD   = 2'b11;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] hold_cnt;
  logic [3:0] hold_cnt_n;
  logic [9:0] instr_n;
  logic [3:0] data_n;
  logic [9:0] cmd_word;
  logic [9:0] start_word;
  logic       accept;
  logic       start;

  assign cmd_word  = {cmd_op, cmd_field, cmd_addr};
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef ISSUER_SKID_EN
  logic       buf_vld;
  logic       buf_vld_n;
  logic [9:0] buf_word;
  logic [9:0] buf_word_n;

  assign cmd_ready = ~rst & ~buf_vld;
`else
  assign cmd_ready = ~rst & (state == IDLE);
`endif

  // Pick what (if anything) starts from IDLE this cycle
  always_comb begin
    start      = 1'b0;
    start_word = cmd_word;
`ifdef ISSUER_SKID_EN
    buf_vld_n  = buf_vld;
    buf_word_n = buf_word;
    if (state == IDLE && buf_vld) begin
      // buffered command has priority; cmd_ready is low so no new accept
      start      = 1'b1;
      start_word = buf_word;
      buf_vld_n  = 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        start = 1'b1;
      end else begin
        buf_vld_n  = 1'b1;
        buf_word_n = cmd_word;
      end
    end
`else
    start = accept;
`endif
  end

  // Next-state and datapath next values
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    instr_n    = instruction;
    data_n     = rsp_data;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = ISSUE;
          instr_n    = start_word;
          hold_cnt_n = 4'd0;
        end else begin
          instr_n = IDLE_WORD;
        end
      end
      ISSUE: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = 4'd0;
          if (instruction[9:8] == OP_LOAD) begin
            // keep the LOAD word one more cycle so res settles
            state_n = CAPTURE;
          end else begin
            state_n = IDLE;
            instr_n = IDLE_WORD;
          end
        end else begin
          hold_cnt_n = hold_cnt + 4'd1;
        end
      end
      CAPTURE: begin
        data_n  = res;
        state_n = RESP;
        instr_n = IDLE_WORD;
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        instr_n = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      instruction <= IDLE_WORD;
      rsp_data    <= 4'd0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      instruction <= instr_n;
      rsp_data    <= data_n;
    end
  end

`ifdef ISSUER_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_word <= 10'd0;
    end else begin
      buf_vld  <= buf_vld_n;
      buf_word <= buf_word_n;
    end
  end
`endif

endmodule
